// File: rtl/axis_switch_route_ctrl.sv
// Per-input routing controller ahead of an axis_switch slave port: stamps tdest
// from a tid-indexed route table, holds the route for the whole packet, drops unroutable packets.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet; route looked up here
// PASS  | forwarding the rest of a routed packet using the latched route
// DROP  | consuming the rest of an unroutable packet, nothing emitted
module axis_switch_route_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 3,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  cfg_wr_en,
    input  logic [ID_WIDTH-1:0]   cfg_addr,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic                  cfg_entry_valid,
    output logic                  stat_drop,
    output logic [CNT_WIDTH-1:0]  stat_drop_count
);

    localparam int TBL_DEPTH = 2 ** ID_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TBL_DEPTH-1:0]                 tbl_valid_q, tbl_valid_d;
    logic [TBL_DEPTH-1:0][DEST_WIDTH-1:0] tbl_dest_q, tbl_dest_d;
    logic [DEST_WIDTH-1:0]                route_q, route_d;

    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic [DEST_WIDTH-1:0] m_dest_q, m_dest_d;
    logic [USER_WIDTH-1:0] m_user_q, m_user_d;

    logic                 drop_q, drop_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                  s_ready;
    logic                  s_accept;
    logic                  lookup_valid;
    logic [DEST_WIDTH-1:0] lookup_dest;
    logic                  load;
    logic [DEST_WIDTH-1:0] load_dest;
    logic [KEEP_WIDTH-1:0] keep_in;
    logic [USER_WIDTH-1:0] user_in;

    // DROP never fills the output register, so it may sink beats even while a stalled beat waits
    assign s_ready      = (state_q == ST_DROP) | ~m_valid_q | m_axis_tready;
    assign s_accept     = s_axis_tvalid & s_ready;
    assign lookup_valid = tbl_valid_q[s_axis_tid];
    assign lookup_dest  = tbl_dest_q[s_axis_tid];
    assign keep_in      = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
    assign user_in      = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    always_comb begin
        state_d     = state_q;
        tbl_valid_d = tbl_valid_q;
        tbl_dest_d  = tbl_dest_q;
        route_d     = route_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_valid_d   = m_valid_q & ~m_axis_tready;
        m_last_d    = m_last_q;
        m_id_d      = m_id_q;
        m_dest_d    = m_dest_q;
        m_user_d    = m_user_q;
        drop_d      = 1'b0;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_dest   = route_q;

        // lookups read the _q copy, so a same-cycle write to the same entry is not seen
        if (cfg_wr_en) begin
            tbl_valid_d[cfg_addr] = cfg_entry_valid;
            tbl_dest_d[cfg_addr]  = cfg_dest;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_accept) begin
                    if (lookup_valid) begin
                        load      = 1'b1;
                        load_dest = lookup_dest;
                        route_d   = lookup_dest;
                        if (!s_axis_tlast) begin
                            state_d = ST_PASS;
                        end
                    end else if (s_axis_tlast) begin
                        drop_d = 1'b1;
                        cnt_d  = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                if (s_accept) begin
                    load      = 1'b1;
                    load_dest = route_q;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (s_accept && s_axis_tlast) begin
                    drop_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_keep_d  = keep_in;
            m_last_d  = s_axis_tlast;
            m_id_d    = s_axis_tid;
            m_dest_d  = load_dest;
            m_user_d  = user_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tbl_valid_q <= '0;
            tbl_dest_q  <= '0;
            route_q     <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_id_q      <= '0;
            m_dest_q    <= '0;
            m_user_q    <= '0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_dest_q  <= tbl_dest_d;
            route_q     <= route_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_id_q      <= m_id_d;
            m_dest_q    <= m_dest_d;
            m_user_q    <= m_user_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
        end
    end

    assign s_axis_tready   = s_ready;
    assign m_axis_tdata    = m_data_q;
    assign m_axis_tkeep    = m_keep_q;
    assign m_axis_tvalid   = m_valid_q;
    assign m_axis_tlast    = m_last_q;
    assign m_axis_tid      = m_id_q;
    assign m_axis_tdest    = m_dest_q;
    assign m_axis_tuser    = m_user_q;
    assign stat_drop       = drop_q;
    assign stat_drop_count = cnt_q;

endmodule

// File: tb/tb_axis_switch_route_ctrl.sv
// Directed bench for axis_switch_route_ctrl: routing, dropping, mid-packet table
// updates, backpressure, back-to-back single beats and reset mid-packet.
module tb_axis_switch_route_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [3:0]  s_axis_tid;
    logic [0:0]  s_axis_tuser;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tid;
    logic [2:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [2:0]  cfg_dest;
    logic        cfg_entry_valid;
    logic        stat_drop;
    logic [31:0] stat_drop_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] cap_data[$];
    logic [7:0]  cap_keep[$];
    logic        cap_last[$];
    logic [3:0]  cap_tid[$];
    logic [2:0]  cap_dest[$];
    logic [0:0]  cap_user[$];
    int          drop_pulses = 0;

    axis_switch_route_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tid      (s_axis_tid),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tdest    (m_axis_tdest),
        .m_axis_tuser    (m_axis_tuser),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_addr        (cfg_addr),
        .cfg_dest        (cfg_dest),
        .cfg_entry_valid (cfg_entry_valid),
        .stat_drop       (stat_drop),
        .stat_drop_count (stat_drop_count)
    );

    always #5 clk = ~clk;

    // Records output handshakes and drop pulses mid-cycle, where everything is settled
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_keep.push_back(m_axis_tkeep);
                cap_last.push_back(m_axis_tlast);
                cap_tid.push_back(m_axis_tid);
                cap_dest.push_back(m_axis_tdest);
                cap_user.push_back(m_axis_tuser);
            end
            if (stat_drop) drop_pulses++;
        end
    end

    function automatic logic [7:0] beat_keep(input int i);
        logic [7:0] k;
        k = 8'hFF;
        return k >> (i % 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        cap_tid.delete();
        cap_dest.delete();
        cap_user.delete();
        drop_pulses = 0;
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [2:0] dest, input logic v);
        cfg_wr_en       = 1'b1;
        cfg_addr        = addr;
        cfg_dest        = dest;
        cfg_entry_valid = v;
        step();
        cfg_wr_en = 1'b0;
    endtask

    // Drives one packet; optionally issues a table write together with beat wr_at
    task automatic drive_pkt(input logic [3:0] tid, input int n, input logic [63:0] base,
                             input int wr_at, input logic [3:0] wr_addr, input logic [2:0] wr_dest);
        int   guard;
        logic acc;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            acc   = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 64'(i);
            s_axis_tkeep  = beat_keep(i);
            s_axis_tlast  = (i == n - 1);
            s_axis_tid    = tid;
            s_axis_tuser  = 1'(i % 2);
            if (i == wr_at) begin
                cfg_wr_en       = 1'b1;
                cfg_addr        = wr_addr;
                cfg_dest        = wr_dest;
                cfg_entry_valid = 1'b1;
            end
            while (!acc && guard < 50) begin
                #3;
                acc = s_axis_tready;
                step();
                cfg_wr_en = 1'b0;
                guard++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout: beat %0d of tid %0d not accepted, got tready=%0b required 1", i, tid, s_axis_tready);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b required 0", m_axis_tvalid); end
        checks++;
        if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %0h required 0", m_axis_tdata); end
        checks++;
        if (m_axis_tdest !== 3'd0) begin errors++; $display("FAIL reset_tdest: got %0d required 0", m_axis_tdest); end
        checks++;
        if (stat_drop !== 1'b0) begin errors++; $display("FAIL reset_stat_drop: got %0b required 0", stat_drop); end
        checks++;
        if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count: got %0d required 0", stat_drop_count); end
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b required 1", s_axis_tready); end
    endtask

    task automatic test_route();
        logic [63:0] base;
        base = 64'hA000_0000_0000_0010;
        m_axis_tready = 1'b1;
        write_entry(4'd2, 3'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 64'(i);
            s_axis_tkeep  = beat_keep(i);
            s_axis_tlast  = (i == 3);
            s_axis_tid    = 4'd2;
            s_axis_tuser  = 1'(i % 2);
            if (i == 0) begin
                #1;
                checks++;
                if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL route_latency_pre: got tvalid=%0b required 0", m_axis_tvalid); end
            end
            step();
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== base + 64'(i) || m_axis_tdest !== 3'd3 ||
                m_axis_tkeep !== beat_keep(i) || m_axis_tlast !== (i == 3) || m_axis_tuser !== 1'(i % 2) ||
                m_axis_tid !== 4'd2) begin
                errors++;
                $display("FAIL route_beat%0d: got v=%0b d=%0h k=%0h l=%0b u=%0b id=%0d dest=%0d required v=1 d=%0h k=%0h l=%0b u=%0b id=2 dest=3",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest,
                         base + 64'(i), beat_keep(i), (i == 3), 1'(i % 2));
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL route_idle_after: got tvalid=%0b required 0", m_axis_tvalid); end
        checks++;
        if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL route_drop_count: got %0d required 0", stat_drop_count); end
    endtask

    task automatic test_drop();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'hD0 + 64'(i);
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = (i == 2);
            s_axis_tid    = 4'd5;
            s_axis_tuser  = 1'b0;
            #1;
            checks++;
            if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL drop_tready%0d: got %0b required 1", i, s_axis_tready); end
            step();
            checks++;
            if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL drop_tvalid%0d: got %0b required 0", i, m_axis_tvalid); end
            checks++;
            if (stat_drop !== (i == 2)) begin errors++; $display("FAIL drop_pulse%0d: got %0b required %0b", i, stat_drop, (i == 2)); end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checks++;
        if (stat_drop_count !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", stat_drop_count); end
        step();
        checks++;
        if (stat_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %0b required 0", stat_drop); end
    endtask

    task automatic test_route_change();
        m_axis_tready = 1'b1;
        write_entry(4'd1, 3'd0, 1'b1);
        clear_capture();
        drive_pkt(4'd1, 6, 64'h1100, 2, 4'd1, 3'd2);
        drive_pkt(4'd1, 2, 64'h1200, -1, 4'd0, 3'd0);
        repeat (2) step();
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("FAIL rc_beat_count: got %0d required 8", cap_data.size()); end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_dest[i] !== ((i < 6) ? 3'd0 : 3'd2) ||
                cap_data[i] !== ((i < 6) ? 64'h1100 + 64'(i) : 64'h1200 + 64'(i - 6))) begin
                errors++;
                $display("FAIL rc_beat%0d: got dest=%0d data=%0h required dest=%0d", i, cap_dest[i], cap_data[i], (i < 6) ? 0 : 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        prev_stall;
        logic [63:0] prev_data;
        logic [2:0]  prev_dest;
        logic        prev_last;
        logic        exp_ready;
        int          stalls;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_dest  = '0;
        prev_last  = 1'b0;
        stalls     = 0;
        write_entry(4'd4, 3'd6, 1'b1);
        clear_capture();
        fork
            drive_pkt(4'd4, 8, 64'hB000, -1, 4'd0, 3'd0);
            begin
                for (int c = 0; c < 30; c++) begin
                    m_axis_tready = (c % 2 == 0);
                    #3;
                    exp_ready = !(m_axis_tvalid && !m_axis_tready);
                    checks++;
                    if (s_axis_tready !== exp_ready) begin
                        errors++;
                        $display("FAIL bp_tready_c%0d: got %0b required %0b", c, s_axis_tready, exp_ready);
                    end
                    if (prev_stall) begin
                        checks++;
                        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                            m_axis_tdest !== prev_dest || m_axis_tlast !== prev_last) begin
                            errors++;
                            $display("FAIL bp_stable_c%0d: got v=%0b d=%0h dest=%0d l=%0b required v=1 d=%0h dest=%0d l=%0b",
                                     c, m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast, prev_data, prev_dest, prev_last);
                        end
                    end
                    prev_stall = m_axis_tvalid && !m_axis_tready;
                    prev_data  = m_axis_tdata;
                    prev_dest  = m_axis_tdest;
                    prev_last  = m_axis_tlast;
                    if (prev_stall) stalls++;
                    step();
                end
                m_axis_tready = 1'b1;
            end
        join
        step();
        checks++;
        if (stalls == 0) begin errors++; $display("FAIL bp_stall_seen: got %0d stalls required >0", stalls); end
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("FAIL bp_beat_count: got %0d required 8", cap_data.size()); end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== 64'hB000 + 64'(i) || cap_dest[i] !== 3'd6 || cap_last[i] !== (i == 7) ||
                cap_keep[i] !== beat_keep(i) || cap_user[i] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL bp_beat%0d: got d=%0h dest=%0d l=%0b k=%0h required d=%0h dest=6 l=%0b k=%0h",
                         i, cap_data[i], cap_dest[i], cap_last[i], cap_keep[i], 64'hB000 + 64'(i), (i == 7), beat_keep(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        m_axis_tready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        write_entry(4'd0, 3'd1, 1'b1);
        clear_capture();
        for (int p = 0; p < 10; p++) begin
            drive_pkt((p % 2 == 0) ? 4'd0 : 4'd7, 1, 64'hC00 + 64'(p), -1, 4'd0, 3'd0);
        end
        repeat (2) step();
        checks++;
        if (cap_data.size() !== 5) begin errors++; $display("FAIL b2b_out_count: got %0d required 5", cap_data.size()); end
        for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_dest[i] !== 3'd1 || cap_tid[i] !== 4'd0 || cap_data[i] !== 64'hC00 + 64'(2 * i) || cap_last[i] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_beat%0d: got dest=%0d tid=%0d d=%0h l=%0b required dest=1 tid=0 d=%0h l=1",
                         i, cap_dest[i], cap_tid[i], cap_data[i], cap_last[i], 64'hC00 + 64'(2 * i));
            end
        end
        checks++;
        if (drop_pulses !== 5) begin errors++; $display("FAIL b2b_drop_pulses: got %0d required 5", drop_pulses); end
        checks++;
        if (stat_drop_count !== 32'd5) begin errors++; $display("FAIL b2b_drop_count: got %0d required 5", stat_drop_count); end
    endtask

    task automatic test_reset_mid_packet();
        m_axis_tready = 1'b1;
        write_entry(4'd2, 3'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'hE0 + 64'(i);
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b0;
            s_axis_tid    = 4'd2;
            s_axis_tuser  = 1'b0;
            if (i == 2) rst = 1'b1;
            step();
            if (i == 0) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdest !== 3'd3) begin
                    errors++;
                    $display("FAIL rmp_first_beat: got v=%0b dest=%0d required v=1 dest=3", m_axis_tvalid, m_axis_tdest);
                end
            end
        end
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmp_tvalid: got %0b required 0", m_axis_tvalid); end
        checks++;
        if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL rmp_count_cleared: got %0d required 0", stat_drop_count); end
        clear_capture();
        drive_pkt(4'd2, 2, 64'hF00, -1, 4'd0, 3'd0);
        repeat (2) step();
        checks++;
        if (cap_data.size() !== 0) begin errors++; $display("FAIL rmp_table_invalid: got %0d outputs required 0", cap_data.size()); end
        checks++;
        if (drop_pulses !== 1 || stat_drop_count !== 32'd1) begin
            errors++;
            $display("FAIL rmp_drop: got pulses=%0d count=%0d required pulses=1 count=1", drop_pulses, stat_drop_count);
        end
        write_entry(4'd2, 3'd3, 1'b1);
        clear_capture();
        drive_pkt(4'd2, 1, 64'hF10, -1, 4'd0, 3'd0);
        repeat (2) step();
        checks++;
        if (cap_data.size() !== 1) begin
            errors++;
            $display("FAIL rmp_reprogram_count: got %0d required 1", cap_data.size());
        end else begin
            checks++;
            if (cap_dest[0] !== 3'd3 || cap_data[0] !== 64'hF10) begin
                errors++;
                $display("FAIL rmp_reprogram_beat: got dest=%0d d=%0h required dest=3 d=f10", cap_dest[0], cap_data[0]);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_axis_tid      = '0;
        s_axis_tuser    = '0;
        m_axis_tready   = 1'b1;
        cfg_wr_en       = 1'b0;
        cfg_addr        = '0;
        cfg_dest        = '0;
        cfg_entry_valid = 1'b0;

        test_reset();
        test_route();
        test_drop();
        test_route_change();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_switch_route_ctrl.md
Name: axis_switch_route_ctrl

Overview:
Per-input routing controller placed in front of each slave port of axis_switch. It stamps tdest on each AXI-stream packet by looking up a software-programmable route table indexed by tid. The route is latched on the first beat and held for the whole packet. Packets whose tid maps to an invalid entry are consumed and dropped, so the switch never sees an unroutable destination.

Parameters:
DATA_WIDTH, 64, tdata width
KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
ID_WIDTH, 4, tid width; route table depth = 2**ID_WIDTH
DEST_WIDTH, 3, tdest width
USER_ENABLE, 1, carry tuser
USER_WIDTH, 1, tuser width
CNT_WIDTH, 32, drop counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input keep
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input last
s_axis_tid  in  ID_WIDTH  input id, route table index
s_axis_tuser  in  USER_WIDTH  input user
m_axis_tdata  out  DATA_WIDTH  output data (to axis_switch s_axis)
m_axis_tkeep  out  KEEP_WIDTH  output keep
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
m_axis_tid  out  ID_WIDTH  output id (passthrough)
m_axis_tdest  out  DEST_WIDTH  stamped destination
m_axis_tuser  out  USER_WIDTH  output user
cfg_wr_en  in  1  route table write strobe
cfg_addr  in  ID_WIDTH  entry index
cfg_dest  in  DEST_WIDTH  destination to store
cfg_entry_valid  in  1  valid bit to store
stat_drop  out  1  one-cycle pulse per dropped packet
stat_drop_count  out  CNT_WIDTH  dropped packet count, wraps

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset: all table valid bits cleared; state IDLE; m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tid/tdest/tuser=0; stat_drop=0; stat_drop_count=0.
- Route table: 2**ID_WIDTH entries of {valid, dest}. A write with cfg_wr_en=1 takes effect on the next cycle. A lookup in the same cycle as a write to the same entry returns the old value.
- Output stage: single register. s_axis_tready = (state==DROP) | ~m_axis_tvalid | m_axis_tready. Latency from input beat to output beat is 1 cycle. Full throughput when m_axis_tready is held high.
- Stable output: m_axis_tvalid and all m_axis_* fields are held until m_axis_tready=1.
- FSM states: IDLE, PASS, DROP.
- IDLE, accepted beat: look up entry[s_axis_tid].
  - Entry valid: load the output register with tdest = entry.dest; latch the route into route_reg; go to PASS if tlast=0, else stay in IDLE.
  - Entry invalid: discard the beat.
    - tlast=1: pulse stat_drop, increment the counter, stay in IDLE.
    - tlast=0: go to DROP.
- PASS, accepted beat: tdest = route_reg. tid is passed through and is not re-looked-up. Return to IDLE on tlast.
- DROP: s_axis_tready=1 unconditionally and beats are discarded. On the tlast beat, pulse stat_drop, increment stat_drop_count (wraps at 2**CNT_WIDTH), go to IDLE.
- Table writes during PASS/DROP do not affect the packet in flight; they take effect from the next first beat.
- No beat is emitted on m_axis for a dropped packet. tvalid-gap input bubbles are tolerated in every state.
- Reset mid-packet: the in-flight output beat is discarded, the table is invalidated, and the state returns to IDLE. The next accepted beat is treated as a first beat.

Test Plan:
- Route: write entry 2 = {valid, dest=3}. Send a 4-beat packet with tid=2 and m_axis_tready=1. Expect 4 output beats with tdest=3, a 1-cycle latency, tdata/tkeep/tlast/tuser matching the input, and stat_drop_count=0.
- Drop: with no entry written, send a 3-beat packet with tid=5. Expect s_axis_tready=1 on all beats, no m_axis_tvalid, one stat_drop pulse coinciding with acceptance of the tlast beat, and stat_drop_count=1.
- Route change mid-packet: entry 1 = dest 0. Start a 6-beat packet with tid=1; after beat 2, write entry 1 = dest 2. Expect all 6 beats with tdest=0, and the next tid=1 packet with tdest=2.
- Backpressure: m_axis_tready toggles 1010… during an 8-beat packet. Expect no loss or duplication, output fields stable while stalled, and s_axis_tready=0 only when the register is full and m_axis_tready=0.
- Single-beat packets back-to-back: alternate tid 0 (valid, dest 1) and tid 7 (invalid) for 10 packets, each with tlast=1. Expect 5 outputs with tdest=1, 5 stat_drop pulses, and stat_drop_count=5.
- Reset mid-packet: assert rst for 1 cycle during beat 3 of a routed packet. Expect m_axis_tvalid=0 the next cycle and the table invalidated, so the following tid=2 packet is dropped until reprogrammed.
